// File: rtl/mc_cu_pkg.sv
// Shared definitions for the mc_cu control unit: FSM states, opcodes,
// PC-control and writeback encodings, and opcode-class decode constants.
package mc_cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEMW,
    ST_INTR,
    ST_HALT
  } state_t;

  typedef enum logic [6:0] {
    OP_LD   = 7'b0010000,
    OP_ST   = 7'b0100000,
    OP_BRZ  = 7'b1100000,
    OP_BRN  = 7'b1100001,
    OP_JMP  = 7'b1110000,
    OP_HALT = 7'b1111111
  } opcode_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_OFF  = 2'b10;
  localparam logic [1:0] PS_LOAD = 2'b11;

  localparam logic [1:0] MD_FU  = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IO  = 2'b10;
  localparam logic [1:0] MD_PC  = 2'b11;

  // Class prefixes matched against the top opcode bits
  localparam logic [2:0] CLS_ALU  = 3'b000;
  localparam logic [1:0] CLS_IMM  = 2'b10;
  localparam logic [2:0] CLS_IOLD = 3'b011;
  localparam logic [2:0] CLS_IOST = 3'b101;

endpackage

// File: rtl/mc_cu_dec.sv
// Combinational opcode-class decoder for the mc_cu control unit.
module mc_cu_dec
  import mc_cu_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       alu,
  output logic       imm,
  output logic       ld,
  output logic       st,
  output logic       io,
  output logic       br,
  output logic       jmp,
  output logic       halt
);

  logic io_ld;
  logic io_st;

  always_comb begin
    io_ld = (opcode[6:4] == CLS_IOLD);
    io_st = (opcode[6:4] == CLS_IOST);
    alu   = (opcode[6:4] == CLS_ALU);
    // The IO-store prefix 101 sits inside the immediate range; IO store wins
    imm   = (opcode[6:5] == CLS_IMM) && !io_st;
    ld    = (opcode == OP_LD) || io_ld;
    st    = (opcode == OP_ST) || io_st;
    io    = io_ld || io_st;
    br    = (opcode == OP_BRZ) || (opcode == OP_BRN);
    jmp   = (opcode == OP_JMP);
    halt  = (opcode == OP_HALT);
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle CPU control unit: fetch/decode/execute sequencing with
// memory/IO wait states, interrupt entry and a reset-only halt state.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter int RAW = 3,
  localparam int IW = 7 + 3*RAW,
  parameter logic [IW-1:0] IRQ_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   ins_in,
  input  logic            z_in,
  input  logic            n_in,
  input  logic            mem_rdy,
  input  logic            irq,
  output logic            il_out,
  output logic            rw_out,
  output logic            mm_out,
  output logic            mb_out,
  output logic            wen_out,
  output logic            iom_out,
  output logic [1:0]      ps_out,
  output logic [3*RAW-1:0] rs_out,
  output logic [1:0]      md_out,
  output logic [3:0]      fs_out,
  output logic            mem_req,
  output logic            vec_sel,
  output logic            irq_ack,
  output logic            halted_out
);

  if ($bits(IRQ_VEC) != IW) begin : g_bad_irq_vec
    $error("IRQ_VEC must be IW bits wide");
  end

  logic [6:0]     opcode;
  logic [RAW-1:0] dr, sa, sb;
  logic [RAW-1:0] da, aa, ba;
  logic cls_alu, cls_imm, cls_ld, cls_st, cls_io, cls_br, cls_jmp, cls_halt;
  logic cls_mem;
  state_t state_reg;

  assign opcode = ins_in[IW-1 -: 7];
  assign dr     = ins_in[3*RAW-1 -: RAW];
  assign sa     = ins_in[2*RAW-1 -: RAW];
  assign sb     = ins_in[RAW-1:0];
  assign cls_mem = cls_ld || cls_st;
  assign rs_out  = {da, aa, ba};

  mc_cu_dec u_dec (
    .opcode (opcode),
    .alu    (cls_alu),
    .imm    (cls_imm),
    .ld     (cls_ld),
    .st     (cls_st),
    .io     (cls_io),
    .br     (cls_br),
    .jmp    (cls_jmp),
    .halt   (cls_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
    end else begin
      case (state_reg)
        ST_FETCH:  if (mem_rdy) state_reg <= ST_DECODE;
        ST_DECODE: state_reg <= ST_EXEC;
        ST_EXEC: begin
          if (cls_mem)       state_reg <= ST_MEMW;
          else if (cls_halt) state_reg <= ST_HALT;
          else if (irq)      state_reg <= ST_INTR;
          else               state_reg <= ST_FETCH;
        end
        ST_MEMW:   if (mem_rdy) state_reg <= irq ? ST_INTR : ST_FETCH;
        ST_INTR:   state_reg <= ST_FETCH;
        ST_HALT:   state_reg <= ST_HALT;
        default:   state_reg <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    il_out     = 1'b0;
    rw_out     = 1'b0;
    mm_out     = 1'b0;
    mb_out     = 1'b0;
    wen_out    = 1'b0;
    iom_out    = 1'b0;
    ps_out     = PS_HOLD;
    md_out     = MD_FU;
    fs_out     = 4'd0;
    mem_req    = 1'b0;
    vec_sel    = 1'b0;
    irq_ack    = 1'b0;
    halted_out = 1'b0;
    da         = '0;
    aa         = '0;
    ba         = '0;
    case (state_reg)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          il_out = 1'b1;
          ps_out = PS_INC;
        end
      end
      ST_EXEC, ST_MEMW: begin
        if (cls_mem) begin
          mem_req = 1'b1;
          mm_out  = 1'b1;
          iom_out = cls_io;
          md_out  = cls_io ? MD_IO : MD_MEM;
          wen_out = cls_st;
          // Load writeback only once the access completes
          rw_out  = cls_ld && (state_reg == ST_MEMW) && mem_rdy;
          da      = dr;
          aa      = sa;
          ba      = sb;
        end else if (state_reg == ST_EXEC) begin
          if (cls_alu || cls_imm) begin
            rw_out = 1'b1;
            mb_out = cls_imm;
            fs_out = opcode[3:0];
            da     = dr;
            aa     = sa;
            ba     = sb;
          end else if (cls_br) begin
            ps_out = ((opcode == OP_BRN) ? n_in : z_in) ? PS_OFF : PS_HOLD;
          end else if (cls_jmp) begin
            ps_out = PS_LOAD;
            aa     = sa;
          end
        end
      end
      ST_INTR: begin
        rw_out  = 1'b1;
        md_out  = MD_PC;
        da      = '1;
        ps_out  = PS_LOAD;
        vec_sel = 1'b1;
        irq_ack = 1'b1;
      end
      ST_HALT: halted_out = 1'b1;
      default: ;
    endcase
    // While reset is held the unit behaves as an idle FETCH
    if (rst) begin
      il_out     = 1'b0;
      rw_out     = 1'b0;
      mm_out     = 1'b0;
      mb_out     = 1'b0;
      wen_out    = 1'b0;
      iom_out    = 1'b0;
      ps_out     = PS_HOLD;
      md_out     = MD_FU;
      fs_out     = 4'd0;
      vec_sel    = 1'b0;
      irq_ack    = 1'b0;
      halted_out = 1'b0;
      da         = '0;
      aa         = '0;
      ba         = '0;
      mem_req    = 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// Directed bench for mc_cu: a cycle-level reference model checked every
// cycle, plus hand-computed spot checks on the key transactions.
module tb_mc_cu;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEMW = 3, P_INTR = 4, P_HALT = 5;
  localparam int K_NOP = 0, K_ALU = 1, K_IMM = 2, K_LD = 3, K_ST = 4, K_IOLD = 5,
                 K_IOST = 6, K_BRZ = 7, K_BRN = 8, K_JMP = 9, K_HALT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ins_in = '0;
  logic        z_in = 1'b0, n_in = 1'b0, mem_rdy = 1'b0, irq = 1'b0;
  logic        il_out, rw_out, mm_out, mb_out, wen_out, iom_out;
  logic [1:0]  ps_out, md_out;
  logic [8:0]  rs_out;
  logic [3:0]  fs_out;
  logic        mem_req, vec_sel, irq_ack, halted_out;
  logic [26:0] act;

  int checks = 0;
  int errors = 0;
  int ph = P_FETCH;

  mc_cu dut (
    .clk(clk), .rst(rst), .ins_in(ins_in), .z_in(z_in), .n_in(n_in),
    .mem_rdy(mem_rdy), .irq(irq), .il_out(il_out), .rw_out(rw_out),
    .mm_out(mm_out), .mb_out(mb_out), .wen_out(wen_out), .iom_out(iom_out),
    .ps_out(ps_out), .rs_out(rs_out), .md_out(md_out), .fs_out(fs_out),
    .mem_req(mem_req), .vec_sel(vec_sel), .irq_ack(irq_ack), .halted_out(halted_out)
  );

  always #5 clk = ~clk;

  assign act = {il_out, rw_out, mm_out, mb_out, wen_out, iom_out, ps_out, rs_out,
                md_out, fs_out, mem_req, vec_sel, irq_ack, halted_out};

  function automatic int kind(input logic [6:0] op);
    if (op == 7'h7F)      return K_HALT;
    if (op == 7'h70)      return K_JMP;
    if (op == 7'h60)      return K_BRZ;
    if (op == 7'h61)      return K_BRN;
    if (op == 7'h10)      return K_LD;
    if (op == 7'h20)      return K_ST;
    if (op / 16 == 3)     return K_IOLD;
    if (op / 16 == 5)     return K_IOST;
    if (op / 16 == 0)     return K_ALU;
    if (op / 32 == 2)     return K_IMM;
    return K_NOP;
  endfunction

  function automatic logic is_mem(input int k);
    return (k == K_LD) || (k == K_ST) || (k == K_IOLD) || (k == K_IOST);
  endfunction

  // Expected output vector for the current cycle, in the same field order as act
  function automatic logic [26:0] model_out(input int p, input logic [15:0] i,
      input logic z, input logic n, input logic rdy, input logic r);
    logic [6:0] op;
    logic [2:0] dr, sa, sb;
    logic il, rw, mm, mb, wen, iom, mreq, vec, ack, hlt;
    logic [1:0] ps, md;
    logic [8:0] rs;
    logic [3:0] fs;
    int k;
    op = i[15:9]; dr = i[8:6]; sa = i[5:3]; sb = i[2:0];
    k = kind(op);
    {il, rw, mm, mb, wen, iom, mreq, vec, ack, hlt} = '0;
    ps = 2'd0; md = 2'd0; rs = 9'd0; fs = 4'd0;
    if (r) begin
      mreq = 1'b1;
    end else if (p == P_FETCH) begin
      mreq = 1'b1;
      if (rdy) begin il = 1'b1; ps = 2'd1; end
    end else if ((p == P_EXEC || p == P_MEMW) && is_mem(k)) begin
      mreq = 1'b1; mm = 1'b1;
      iom = (k == K_IOLD) || (k == K_IOST);
      md = iom ? 2'd2 : 2'd1;
      wen = (k == K_ST) || (k == K_IOST);
      rw = !wen && (p == P_MEMW) && rdy;
      rs = {dr, sa, sb};
    end else if (p == P_EXEC) begin
      if (k == K_ALU || k == K_IMM) begin
        rw = 1'b1; mb = (k == K_IMM); fs = op[3:0]; rs = {dr, sa, sb};
      end else if (k == K_BRZ) ps = z ? 2'd2 : 2'd0;
      else if (k == K_BRN) ps = n ? 2'd2 : 2'd0;
      else if (k == K_JMP) begin ps = 2'd3; rs = {3'd0, sa, 3'd0}; end
    end else if (p == P_INTR) begin
      rw = 1'b1; md = 2'd3; rs = 9'b111_000_000; ps = 2'd3; vec = 1'b1; ack = 1'b1;
    end else if (p == P_HALT) begin
      hlt = 1'b1;
    end
    return {il, rw, mm, mb, wen, iom, ps, rs, md, fs, mreq, vec, ack, hlt};
  endfunction

  always @(posedge clk) begin
    if (rst) ph <= P_FETCH;
    else case (ph)
      P_FETCH:  if (mem_rdy) ph <= P_DECODE;
      P_DECODE: ph <= P_EXEC;
      P_EXEC: begin
        if (is_mem(kind(ins_in[15:9])))     ph <= P_MEMW;
        else if (kind(ins_in[15:9]) == K_HALT) ph <= P_HALT;
        else                                ph <= irq ? P_INTR : P_FETCH;
      end
      P_MEMW:   if (mem_rdy) ph <= irq ? P_INTR : P_FETCH;
      P_INTR:   ph <= P_FETCH;
      default:  ph <= ph;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    check("cycle", 32'(act), 32'(model_out(ph, ins_in, z_in, n_in, mem_rdy, rst)));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Enter FETCH at the next edge, fetch immediately, return in the EXEC cycle
  task automatic issue(input logic [15:0] i, input string nm);
    tick();
    ins_in = i;
    mem_rdy = 1'b1;
    $display("txn %s ins=%h", nm, i);
    tick();
    tick();
  endtask

  initial begin
    tick(); tick(); #4;
    $display("txn RESET");
    check("rst_mem_req", 32'(mem_req), 1);
    check("rst_others", 32'(act & ~27'h8), 0);
    tick(); rst = 1'b0; #4;
    check("post_rst_il", 32'(il_out), 0);
    check("post_rst_halted", 32'(halted_out), 0);

    tick(); ins_in = 16'h0453; mem_rdy = 1'b1; #4;
    $display("txn ADD ins=%h", ins_in);
    check("add_fetch_il", 32'(il_out), 1);
    check("add_fetch_ps", 32'(ps_out), 1);
    tick(); #4;
    check("add_decode_quiet", 32'(act), 0);
    tick(); #4;
    check("add_exec_rw", 32'(rw_out), 1);
    check("add_exec_fs", 32'(fs_out), 32'h2);
    check("add_exec_rs", 32'(rs_out), 32'h053);
    mem_rdy = 1'b0;
    tick(); #4;
    check("add_back_fetch", 32'(mem_req), 1);

    issue(16'h2128, "LD");
    mem_rdy = 1'b0; #4;
    check("ld_exec_mm", 32'(mm_out), 1);
    check("ld_exec_md", 32'(md_out), 1);
    check("ld_exec_rw", 32'(rw_out), 0);
    repeat (3) begin
      tick(); #4;
      check("ld_wait_rw", 32'(rw_out), 0);
      check("ld_wait_req", 32'(mem_req), 1);
    end
    tick(); mem_rdy = 1'b1; #4;
    check("ld_done_rw", 32'(rw_out), 1);
    check("ld_done_req", 32'(mem_req), 1);

    z_in = 1'b1;
    issue(16'hC000, "BRZ_taken"); #4;
    check("brz_taken_ps", 32'(ps_out), 2);
    z_in = 1'b0;
    issue(16'hC000, "BRZ_not"); #4;
    check("brz_not_ps", 32'(ps_out), 0);
    n_in = 1'b1;
    issue(16'hC200, "BRN_taken"); #4;
    check("brn_taken_ps", 32'(ps_out), 2);
    issue(16'hE018, "JMP"); #4;
    n_in = 1'b0;
    check("jmp_ps", 32'(ps_out), 3);
    check("jmp_rs", 32'(rs_out), 32'h018);
    issue(16'h8648, "IMM"); #4;
    check("imm_mb", 32'(mb_out), 1);
    issue(16'h6130, "IOLD"); tick();
    issue(16'hA00A, "IOST"); tick();
    issue(16'hD400, "NOP"); #4;
    check("nop_quiet", 32'(act), 0);

    issue(16'h400A, "ST_irq");
    mem_rdy = 1'b0; #4;
    check("st_exec_wen", 32'(wen_out), 1);
    tick(); irq = 1'b1; #4;
    check("st_wait_wen", 32'(wen_out), 1);
    check("st_wait_rw", 32'(rw_out), 0);
    tick(); mem_rdy = 1'b1; #4;
    check("st_done_wen", 32'(wen_out), 1);
    tick(); #4;
    check("intr_rs", 32'(rs_out), 32'h1C0);
    check("intr_md", 32'(md_out), 3);
    check("intr_vec", 32'(vec_sel), 1);
    check("intr_ack", 32'(irq_ack), 1);
    tick(); mem_rdy = 1'b0; #4;
    check("intr_ack_once", 32'(irq_ack), 0);
    irq = 1'b0;

    issue(16'h2128, "LD_lost_irq");
    mem_rdy = 1'b0;
    tick(); irq = 1'b1; #4;
    tick(); irq = 1'b0; mem_rdy = 1'b1; #4;
    check("lost_irq_wb", 32'(rw_out), 1);
    tick(); mem_rdy = 1'b0; #4;
    check("lost_irq_no_ack", 32'(irq_ack), 0);

    issue(16'h400A, "ST_rst");
    mem_rdy = 1'b0;
    tick(); #4;
    check("st_rst_wen_before", 32'(wen_out), 1);
    tick(); rst = 1'b1; #4;
    check("st_rst_wen_during", 32'(wen_out), 0);
    tick(); rst = 1'b0; #4;
    check("st_rst_wen_after", 32'(wen_out), 0);
    check("st_rst_fetch", 32'(mem_req), 1);

    issue(16'hFE00, "HALT"); #4;
    check("halt_exec_quiet", 32'(act), 0);
    tick(); irq = 1'b1; #4;
    check("halted", 32'(halted_out), 1);
    check("halt_no_ack", 32'(irq_ack), 0);
    repeat (9) begin
      tick(); #4;
      check("halted", 32'(halted_out), 1);
      check("halt_no_ack", 32'(irq_ack), 0);
    end
    tick(); rst = 1'b1; #4;
    check("halt_rst_halted", 32'(halted_out), 0);
    tick(); rst = 1'b0; irq = 1'b0; #4;
    check("halt_exit_halted", 32'(halted_out), 0);
    check("halt_exit_fetch", 32'(mem_req), 1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
